// File: rtl/instr_enc.sv
// MIPS instruction encoder feeding a 2-entry output FIFO with a valid/ready handshake.
// Optional macro INSTR_ENC_DWORD_EN enables the LD/SD kinds (14/15); otherwise they are illegal.
module instr_enc (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [15:0] enc_count
);

  logic [31:0] enc_word;
  logic        enc_legal;

  logic [1:0]  occ_q, occ_d;
  logic [31:0] head_q, head_d, tail_q, tail_d;
  logic        in_ready_q, err_q;
  logic [15:0] cnt_q;
  logic        acc, push, pop;

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (in_kind)
      4'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      4'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      4'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd5:  enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd7:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd8:  enc_word = {6'b001100, in_rs, in_rt, in_imm};
      4'd9:  enc_word = {6'b001101, in_rs, in_rt, in_imm};
      4'd10: enc_word = {6'b001010, in_rs, in_rt, in_imm};
      4'd11: enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd12: enc_word = {6'b000101, in_rs, in_rt, in_imm};
      4'd13: enc_word = {6'b000010, in_target};
`ifdef INSTR_ENC_DWORD_EN
      4'd14: enc_word = {6'b110111, in_rs, in_rt, in_imm};
      4'd15: enc_word = {6'b111111, in_rs, in_rt, in_imm};
`else
      4'd14: enc_legal = 1'b0;
      4'd15: enc_legal = 1'b0;
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  // Illegal kinds still complete the handshake but never reach the FIFO.
  assign acc  = in_valid && in_ready_q;
  assign push = acc && enc_legal;
  assign pop  = (occ_q != 2'd0) && out_ready;

  assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

  // head_q is always the oldest word; a push lands in head when head is free after this edge.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop) head_d = tail_q;
    if (push) begin
      if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) head_d = enc_word;
      else                                         tail_d = enc_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (occ_d != 2'd2);
      err_q      <= acc && !enc_legal;
      cnt_q      <= cnt_q + {15'd0, pop};
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_instr = head_q;
  assign err       = err_q;
  assign enc_count = cnt_q;

endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port in_valid, input, 1, encode request valid.
REQ-004 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready at a rising edge.
REQ-005 SHALL have port in_kind, input, 4, instruction kind: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 ADDI, 8 ANDI, 9 ORI, 10 SLTI, 11 BEQ, 12 BNE, 13 J, 14 LD, 15 SD.
REQ-006 SHALL have ports in_rs, in_rt, in_rd, input, 5 each, register fields.
REQ-007 SHALL have port in_imm, input, 16, immediate or branch offset.
REQ-008 SHALL have port in_target, input, 26, jump target.
REQ-009 SHALL have port out_valid, output, 1, out_instr holds a valid word.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the word when out_valid && out_ready.
REQ-011 SHALL have port out_instr, output, 32, encoded MIPS instruction word.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on an accepted illegal kind.
REQ-013 SHALL have port enc_count, output, 16, number of words delivered on the output.

Function
REQ-014 SHALL encode R-type kinds 0-4 as {6'b000000, rs, rt, rd, 5'b00000, funct}, funct 100000/100010/100100/100101/101010 respectively.
REQ-015 SHALL encode I-type kinds as {op, rs, rt, imm}, op: LW 100011, SW 101011, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, BEQ 000100, BNE 000101, LD 110111, SD 111111.
REQ-016 SHALL encode J as {6'b000010, target}; in_rs/in_rt/in_rd/in_imm ignored for J, in_rd and in_target ignored for I-type.
REQ-017 SHALL buffer encoded words in a 2-entry FIFO; in_ready = (occupancy < 2), registered, no combinational path from out_ready.
REQ-018 SHALL present the FIFO head on out_instr with out_valid = (occupancy != 0); out_instr stable while out_valid && !out_ready.
REQ-019 SHALL give a latency of 1 cycle: word accepted at edge N is visible on out_valid/out_instr after edge N when FIFO was empty.
REQ-020 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy 1 with the new word at head after the edge; at occupancy 2 no push occurs (in_ready low).
REQ-021 SHALL accept an illegal kind (in_ready high), not enqueue it, and assert err for exactly the next cycle.
REQ-022 SHALL increment enc_count on each output handshake, wrapping 16'hFFFF -> 16'h0000.
REQ-023 SHALL preserve FIFO order; no word dropped or duplicated.

Reset
REQ-024 SHALL, while reset is 0, force occupancy 0, in_ready 0, out_valid 0, out_instr 32'h0, err 0, enc_count 0, asynchronously.
REQ-025 SHALL discard any buffered words on reset mid-operation and assert in_ready 1 on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro INSTR_ENC_DWORD_EN defined, encode kinds 14 (LD) and 15 (SD) per REQ-015.
REQ-027 SHALL, without INSTR_ENC_DWORD_EN, treat kinds 14 and 15 as illegal per REQ-021.

Verification
REQ-028 SHALL test: ADD rs=1 rt=2 rd=3, out_ready=1 -> out_instr 32'h00221820 one cycle later, enc_count 1.
REQ-029 SHALL test: LW rs=29 rt=8 imm=16'h0004 then J target=26'h0000010 back-to-back -> 32'h8FA80004 then 32'h08000010 in order.
REQ-030 SHALL test: out_ready=0, push three ADDI -> in_ready low after two accepts, third held; release out_ready -> all three delivered in order.
REQ-031 SHALL test: kind 15 without INSTR_ENC_DWORD_EN -> accepted, err pulses 1 cycle, no word; with macro, SD rs=0 rt=1 imm=8 -> 32'hFC010008.
REQ-032 SHALL test: reset=0 while FIFO holds 2 words -> out_valid 0, enc_count 0 immediately; after release, in_ready 1 and no stale output.
REQ-033 SHALL test: preload enc_count to 16'hFFFF via 65535 handshakes -> next handshake wraps enc_count to 16'h0000.
